psum_accum_ctrl: RTL and testbench



---
 rtl/psum_accum_ctrl_pkg.sv | 20 ++
 rtl/psum_out_fifo.sv | 63 ++++++
 rtl/psum_accum_ctrl.sv | 123 ++++++++++++
 tb/tb_psum_accum_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_ctrl_pkg.sv
// Shared psum widths and the output FIFO entry layout.
// The psum BRAM and the writeback stage use the same definitions.
package psum_accum_ctrl_pkg;

    localparam int unsigned PSUM_DATA_WIDTH  = 32;
    localparam int unsigned PSUM_ADDR_WIDTH  = 32;
    localparam int unsigned PSUM_OFIFO_DEPTH = 4;

    // Final-sum beat as it leaves toward writeback: address in the upper bits.
    typedef struct packed {
        logic [PSUM_ADDR_WIDTH-1:0] addr;
        logic [PSUM_DATA_WIDTH-1:0] data;
    } psum_entry_t;

    // Occupancy counter width: it must be able to hold the value depth itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// First-word-fall-through FIFO for final psum beats, exposing its occupancy.
// DEPTH must be a power of two (>= 2), so the pointers wrap naturally.
module psum_out_fifo
    import psum_accum_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(psum_entry_t),
    parameter int unsigned DEPTH = PSUM_OFIFO_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign o_valid = (r_count != '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop & o_valid;
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_count = r_count;
    // Output is zeroed when empty so reset/idle values are deterministic.
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/psum_accum_ctrl.sv
// Read-modify-write psum accumulator in front of a 1-cycle-read BRAM.
// Final sums are also queued toward writeback under a credit check.
module psum_accum_ctrl
    import psum_accum_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = PSUM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = PSUM_ADDR_WIDTH,
    parameter int unsigned OFIFO_DEPTH = PSUM_OFIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_psum,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic [ADDR_WIDTH-1:0] bram_raddr,
    input  logic [DATA_WIDTH-1:0] bram_odat,
    output logic [ADDR_WIDTH-1:0] bram_waddr,
    output logic [DATA_WIDTH-1:0] bram_idat,
    output logic                  bram_wren,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    localparam int unsigned   CNT_W      = cnt_width(OFIFO_DEPTH);
    localparam int unsigned   ENTRY_W    = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(OFIFO_DEPTH);

    logic                  r_released;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic                  r_s1_valid;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [DATA_WIDTH-1:0] r_s1_psum;
    logic                  r_s1_first;
    logic                  r_s1_last;
    logic                  r_fwd;
    logic [DATA_WIDTH-1:0] r_fwd_data;

    logic                  w_accept;
    logic                  w_hazard;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [CNT_W:0]        w_credit_used;
    logic                  w_fifo_push;
    logic [ENTRY_W-1:0]    w_fifo_wdata;
    logic [ENTRY_W-1:0]    w_fifo_rdata;

    // The beat in S1 has already claimed its FIFO slot, so S1 never has to stall.
    assign w_credit_used = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_s1_valid & r_s1_last};
    assign in_ready      = r_released & (w_credit_used < CREDIT_MAX);
    assign w_accept      = in_valid & in_ready;
    assign bram_raddr    = w_accept ? in_addr : r_raddr;

    // A distance-1 same-address beat would read pre-write data from the BRAM.
    assign w_hazard = r_s1_valid & (in_addr == r_s1_addr);

    always_comb begin
        w_old = bram_odat;
        if (r_s1_first) begin
            w_old = '0;
        end else if (r_fwd) begin
            w_old = r_fwd_data;
        end
    end

    assign w_sum      = w_old + r_s1_psum;
    assign bram_wren  = r_s1_valid;
    assign bram_waddr = r_s1_valid ? r_s1_addr : '0;
    assign bram_idat  = r_s1_valid ? w_sum : '0;

    assign w_fifo_push  = r_s1_valid & r_s1_last;
    assign w_fifo_wdata = {r_s1_addr, w_sum};
    assign out_addr     = w_fifo_rdata[ENTRY_W-1 -: ADDR_WIDTH];
    assign out_data     = w_fifo_rdata[DATA_WIDTH-1:0];
    assign busy         = r_s1_valid | out_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_released <= 1'b0;
            r_raddr    <= '0;
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_psum  <= '0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_released <= 1'b1;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_raddr    <= in_addr;
                r_s1_addr  <= in_addr;
                r_s1_psum  <= in_psum;
                r_s1_first <= in_first;
                r_s1_last  <= in_last;
                r_fwd      <= w_hazard;
                r_fwd_data <= w_sum;
            end
        end
    end

    psum_out_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (OFIFO_DEPTH)
    ) u_out_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_fifo_push),
        .i_push_data (w_fifo_wdata),
        .i_pop       (out_ready),
        .o_valid     (out_valid),
        .o_data      (w_fifo_rdata),
        .o_count     (w_fifo_count)
    );

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Self-checking bench for psum_accum_ctrl: directed cases plus randomized traffic
// against a beat-level model of memory contents and the final-sum stream.
module tb_psum_accum_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_psum = '0;
    logic        in_ready;
    logic        bram_wren;
    logic        out_valid;
    logic        busy;
    logic [31:0] bram_raddr;
    logic [31:0] bram_waddr;
    logic [31:0] out_addr;
    logic [31:0] bram_odat;
    logic [31:0] bram_idat;
    logic [31:0] out_data;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic [31:0] bram_mem [16] = '{default: '0};
    logic [31:0] ref_mem  [16] = '{default: '0};
    beat_t       exp_out [$];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic        pend_v = 1'b0;
    logic        pend_l = 1'b0;
    logic [3:0]  pend_a = '0;
    logic [31:0] pend_sum = '0;
    logic [31:0] pend_prev = '0;
    logic        rnd_oready = 1'b0;
    int          n_out = 0;
    logic [31:0] last_out_addr = '0;
    logic [31:0] last_out_data = '0;

    always #5 clk = ~clk;

    psum_accum_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_psum    (in_psum),
        .in_first   (in_first),
        .in_last    (in_last),
        .bram_raddr (bram_raddr),
        .bram_odat  (bram_odat),
        .bram_waddr (bram_waddr),
        .bram_idat  (bram_idat),
        .bram_wren  (bram_wren),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy)
    );

    // Read-first BRAM with a registered read port.
    always @(posedge clk) begin
        bram_odat <= bram_mem[bram_raddr[3:0]];
        if (bram_wren) bram_mem[bram_waddr[3:0]] <= bram_idat;
        if (pre_en) bram_mem[pre_addr] <= pre_data;
    end

    always @(posedge clk) begin
        if (rnd_oready) begin
            #1;
            out_ready = ($urandom % 10) < 7;
        end
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endfunction

    // Model: each accepted beat updates memory immediately in accept order; the DUT
    // must write that value one cycle later. The final-sum queue holds every accepted
    // last beat not yet popped, which is exactly the credit the DUT may have used.
    always @(negedge clk) begin : compare
        int fifo_n;
        logic [3:0] a;
        if (!rst) begin
            chk("rst_wren", bram_wren, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_busy", busy, 0);
            if (pend_v) ref_mem[pend_a] = pend_prev;
            pend_v = 1'b0;
            exp_out.delete();
        end else begin
            chk("wren", bram_wren, pend_v);
            if (pend_v) begin
                chk("waddr", bram_waddr, 32'(pend_a));
                chk("idat", bram_idat, pend_sum);
            end
            fifo_n = exp_out.size() - ((pend_v && pend_l) ? 1 : 0);
            chk("out_valid", out_valid, fifo_n > 0);
            if (out_valid && fifo_n > 0) begin
                chk("out_addr", out_addr, exp_out[0].addr);
                chk("out_data", out_data, exp_out[0].data);
            end
            chk("in_ready", in_ready, exp_out.size() < DEPTH);
            chk("busy", busy, pend_v || fifo_n > 0);
            if (out_valid && out_ready && fifo_n > 0) begin
                last_out_addr = exp_out[0].addr;
                last_out_data = exp_out[0].data;
                void'(exp_out.pop_front());
                n_out++;
            end
            pend_v = 1'b0;
            if (in_valid && in_ready) begin
                a         = in_addr[3:0];
                pend_prev = ref_mem[a];
                pend_sum  = (in_first ? 32'd0 : ref_mem[a]) + in_psum;
                ref_mem[a] = pend_sum;
                pend_a    = a;
                pend_v    = 1'b1;
                pend_l    = in_last;
                if (in_last) exp_out.push_back({32'(a), pend_sum});
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the beat until accepted; returns just after the accepting edge.
    task automatic send(input int a, input logic [31:0] p, input logic f, input logic l);
        in_addr  = 32'(a);
        in_psum  = p;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        pre_en   = 1'b1;
        pre_addr = 4'(a);
        pre_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            out_ready = 1'b1;
            if (exp_out.size() == 0 && !pend_v) begin
                idle(2);
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", 0, 1);
    endtask

    initial begin : driver
        int n0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single first+last beat.
        out_ready = 1'b1;
        send(5, 32'd7, 1'b1, 1'b1);
        in_valid = 1'b0;
        chk("t1_wren", bram_wren, 1);
        chk("t1_waddr", bram_waddr, 5);
        chk("t1_idat", bram_idat, 7);
        drain();
        chk("t1_out_addr", last_out_addr, 5);
        chk("t1_out_data", last_out_data, 7);
        chk("t1_mem", bram_mem[5], 7);

        // Back-to-back same address relies on forwarding.
        preload(3, 32'd100);
        send(3, 32'd1, 1'b0, 1'b0);
        chk("t2_idat0", bram_idat, 101);
        send(3, 32'd2, 1'b0, 1'b0);
        chk("t2_idat1", bram_idat, 103);
        send(3, 32'd3, 1'b0, 1'b1);
        chk("t2_idat2", bram_idat, 106);
        drain();
        chk("t2_mem", bram_mem[3], 106);

        // Interleaved addresses (distance-2 reuse goes through the BRAM).
        send(1, 32'd10, 1'b1, 1'b0);
        send(2, 32'd20, 1'b1, 1'b0);
        send(1, 32'd1, 1'b0, 1'b0);
        send(2, 32'd2, 1'b0, 1'b1);
        drain();
        chk("t3_mem1", bram_mem[1], 11);
        chk("t3_mem2", bram_mem[2], 22);

        // Modular wrap.
        preload(6, 32'hFFFF_FFFF);
        send(6, 32'd2, 1'b0, 1'b1);
        in_valid = 1'b0;
        chk("t4_idat", bram_idat, 1);
        drain();

        // Backpressure: four queued finals exhaust the credit.
        n0 = n_out;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8 + i, 32'(i + 1), 1'b1, 1'b1);
        in_valid = 1'b0;
        idle(2);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_out_valid", out_valid, 1);
        in_addr = 32'd12; in_psum = 32'd5; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_blocked_wren", bram_wren, 0);
        out_ready = 1'b1;
        send(12, 32'd5, 1'b1, 1'b1);
        send(13, 32'd6, 1'b1, 1'b1);
        drain();
        chk("t5_n_out", n_out - n0, 6);
        chk("t5_last_addr", last_out_addr, 13);
        chk("t5_mem11", bram_mem[11], 4);

        // Reset with a beat in S1 and one in the FIFO.
        out_ready = 1'b0;
        send(14, 32'd1, 1'b1, 1'b1);
        send(4, 32'd9, 1'b1, 1'b1);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("t6_wren", bram_wren, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_in_ready", in_ready, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_in_ready_after", in_ready, 1);
        chk("t6_busy_after", busy, 0);
        chk("t6_mem4", bram_mem[4], 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic with random output backpressure.
        rnd_oready = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (($urandom % 4) == 0) idle(1);
            send(int'($urandom % 8), $urandom, ($urandom % 4) == 0, ($urandom % 3) == 0);
        end
        rnd_oready = 1'b0;
        drain();
        for (int i = 0; i < 16; i++) chk($sformatf("mem_%0d", i), bram_mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
